// File: rtl/kmkz_writeback_if.sv
`default_nettype none
// ============================================================================
//  Module      : kmkz_writeback_if
//  Description : Execute/data-memory side signals of the writeback stage.
//  Revision    : 1.0 - initial release
// ============================================================================
interface kmkz_writeback_if;
  logic        x_valid_i;
  logic [4:0]  x_rd_i;
  logic [31:0] x_rd_value_i;
  logic        x_rd_write_i;
  logic        x_load_i;
  logic        x_store_i;
  logic [2:0]  x_fun_i;
  logic [1:0]  x_dm_addr_i;
  logic [31:0] dm_data_l_i;
  logic        dm_load_done_i;
  logic        dm_store_done_i;
  logic        w_stall_o;
  logic [4:0]  w_rd_o;
  logic [31:0] w_rd_value_o;
  logic        w_rd_store_o;
  logic        w_bypass_rd_write_o;
  logic [31:0] w_bypass_rd_value_o;
  logic        w_misaligned_o;
  logic        w_bus_error_o;

  modport master (
    output x_valid_i, x_rd_i, x_rd_value_i, x_rd_write_i, x_load_i, x_store_i,
           x_fun_i, x_dm_addr_i, dm_data_l_i, dm_load_done_i, dm_store_done_i,
    input  w_stall_o, w_rd_o, w_rd_value_o, w_rd_store_o, w_bypass_rd_write_o,
           w_bypass_rd_value_o, w_misaligned_o, w_bus_error_o
  );

  modport slave (
    input  x_valid_i, x_rd_i, x_rd_value_i, x_rd_write_i, x_load_i, x_store_i,
           x_fun_i, x_dm_addr_i, dm_data_l_i, dm_load_done_i, dm_store_done_i,
    output w_stall_o, w_rd_o, w_rd_value_o, w_rd_store_o, w_bypass_rd_write_o,
           w_bypass_rd_value_o, w_misaligned_o, w_bus_error_o
  );
endinterface
`default_nettype wire

// File: rtl/kmkz_writeback.sv
`default_nettype none
// ============================================================================
//  Module      : kmkz_writeback
//  Description : Writeback stage: waits on data memory, aligns loads, drives
//                the register-file write port and bypass. Optional load
//                timeout enabled by KMKZ_WB_LOAD_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module kmkz_writeback #(
  parameter int unsigned LOAD_TIMEOUT = 255
) (
  input wire               clk_i,
  input wire               rst_i,
  kmkz_writeback_if.slave  wb
);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_WAIT_LOAD  = 2'd1,
    S_WAIT_STORE = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_valid;
  logic [4:0]  r_rd;
  logic [31:0] r_rd_value;
  logic        r_rd_write;
  logic        r_load;
  logic        r_store;
  logic [2:0]  r_fun;
  logic [1:0]  r_addr;

  logic        w_stall;
  logic        w_load_done;
  logic        w_store_done;
  logic        w_timeout;
  logic        w_misaligned;
  logic        w_complete;
  logic        w_write;
  state_t      w_next_state;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;
  logic [31:0] w_value;

  // Halfword needs addr[0]=0, word needs addr=0; unknown funct3 acts as LW.
  function automatic logic misaligned_f(input logic [2:0] fun, input logic [1:0] addr);
    case (fun)
      3'b000, 3'b100: misaligned_f = 1'b0;
      3'b001, 3'b101: misaligned_f = addr[0];
      default:        misaligned_f = (addr != 2'b00);
    endcase
  endfunction

`ifdef KMKZ_WB_LOAD_TIMEOUT_EN
  localparam int unsigned C_CNT_W = $clog2(LOAD_TIMEOUT + 1);
  logic [C_CNT_W-1:0] r_cnt;
  assign w_timeout = (r_state == S_WAIT_LOAD) && !wb.dm_load_done_i &&
                     (r_cnt == C_CNT_W'(LOAD_TIMEOUT));
`else
  logic w_unused_cfg;
  assign w_unused_cfg = LOAD_TIMEOUT[0];
  assign w_timeout    = 1'b0;
`endif

  assign w_load_done  = (r_state == S_WAIT_LOAD) && wb.dm_load_done_i;
  assign w_store_done = (r_state == S_WAIT_STORE) && wb.dm_store_done_i;
  assign w_stall      = ((r_state == S_WAIT_LOAD) && !wb.dm_load_done_i && !w_timeout) ||
                        ((r_state == S_WAIT_STORE) && !wb.dm_store_done_i);

  // Next state is decided by the instruction being captured on this edge.
  always_comb begin
    w_next_state = S_IDLE;
    if (wb.x_valid_i && wb.x_load_i && !misaligned_f(wb.x_fun_i, wb.x_dm_addr_i))
      w_next_state = S_WAIT_LOAD;
    else if (wb.x_valid_i && wb.x_store_i)
      w_next_state = S_WAIT_STORE;
  end

  always_comb begin
    w_byte = wb.dm_data_l_i[7:0];
    case (r_addr)
      2'd1:    w_byte = wb.dm_data_l_i[15:8];
      2'd2:    w_byte = wb.dm_data_l_i[23:16];
      2'd3:    w_byte = wb.dm_data_l_i[31:24];
      default: w_byte = wb.dm_data_l_i[7:0];
    endcase
    w_half = r_addr[1] ? wb.dm_data_l_i[31:16] : wb.dm_data_l_i[15:0];
    case (r_fun)
      3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load_data = {24'h0, w_byte};
      3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
      3'b101:  w_load_data = {16'h0, w_half};
      default: w_load_data = wb.dm_data_l_i;
    endcase
  end

  assign w_misaligned = r_valid && r_load && misaligned_f(r_fun, r_addr);
  assign w_complete   = r_load ? w_load_done : !r_store;
  assign w_write      = r_valid && r_rd_write && (r_rd != 5'd0) && w_complete && !w_misaligned;
  assign w_value      = r_load ? w_load_data : r_rd_value;

  assign wb.w_stall_o           = w_stall;
  assign wb.w_rd_o              = r_rd;
  assign wb.w_rd_store_o        = w_write;
  assign wb.w_rd_value_o        = w_write ? w_value : 32'h0;
  assign wb.w_bypass_rd_write_o = w_write;
  assign wb.w_bypass_rd_value_o = w_write ? w_value : 32'h0;
  assign wb.w_misaligned_o      = w_misaligned;
  assign wb.w_bus_error_o       = w_timeout;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state    <= S_IDLE;
      r_valid    <= 1'b0;
      r_rd       <= 5'd0;
      r_rd_value <= 32'h0;
      r_rd_write <= 1'b0;
      r_load     <= 1'b0;
      r_store    <= 1'b0;
      r_fun      <= 3'd0;
      r_addr     <= 2'd0;
`ifdef KMKZ_WB_LOAD_TIMEOUT_EN
      r_cnt      <= '0;
`endif
    end else if (!w_stall) begin
      r_state    <= w_next_state;
      r_valid    <= wb.x_valid_i;
      r_rd       <= wb.x_rd_i;
      r_rd_value <= wb.x_rd_value_i;
      r_rd_write <= wb.x_rd_write_i;
      r_load     <= wb.x_load_i;
      r_store    <= wb.x_store_i;
      r_fun      <= wb.x_fun_i;
      r_addr     <= wb.x_dm_addr_i;
`ifdef KMKZ_WB_LOAD_TIMEOUT_EN
      r_cnt      <= '0;
`endif
    end else begin
`ifdef KMKZ_WB_LOAD_TIMEOUT_EN
      if (r_state == S_WAIT_LOAD)
        r_cnt <= r_cnt + 1'b1;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_kmkz_writeback.sv
`default_nettype none
// ============================================================================
//  Module      : tb_kmkz_writeback
//  Description : Directed vector bench for kmkz_writeback.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_kmkz_writeback;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  kmkz_writeback_if wbif ();

`ifdef KMKZ_WB_LOAD_TIMEOUT_EN
  kmkz_writeback #(.LOAD_TIMEOUT(4)) dut (.clk_i(clk), .rst_i(rst_n), .wb(wbif.slave));
`else
  kmkz_writeback dut (.clk_i(clk), .rst_i(rst_n), .wb(wbif.slave));
`endif

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] val;
    logic        wr;
    logic        ld;
    logic        st;
    logic [2:0]  fun;
    logic [1:0]  addr;
    logic [31:0] data;
    int          delay;
    logic        e_store;
    logic [31:0] e_val;
    logic        e_mis;
    int          e_stall;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic set_x(input logic v, input logic [4:0] rd, input logic [31:0] val,
                       input logic wr, input logic ld, input logic st,
                       input logic [2:0] fun, input logic [1:0] addr);
    wbif.x_valid_i    = v;
    wbif.x_rd_i       = rd;
    wbif.x_rd_value_i = val;
    wbif.x_rd_write_i = wr;
    wbif.x_load_i     = ld;
    wbif.x_store_i    = st;
    wbif.x_fun_i      = fun;
    wbif.x_dm_addr_i  = addr;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int stalls;
    string tag;
    stalls = 0;
    tag = $sformatf("v%0d", idx);
    @(negedge clk);
    set_x(1'b1, v.rd, v.val, v.wr, v.ld, v.st, v.fun, v.addr);
    wbif.dm_data_l_i = v.data;
    @(posedge clk);
    #1;
    wbif.x_valid_i = 1'b0;
    if ((v.ld || v.st) && !v.e_mis) begin
      for (int c = 0; c < 20; c++) begin
        if (c == v.delay) begin
          if (v.ld) wbif.dm_load_done_i = 1'b1;
          else      wbif.dm_store_done_i = 1'b1;
        end
        #1;
        if (c == v.delay) break;
        if (wbif.w_stall_o) stalls++;
        check({tag, "_wait_store"}, {31'h0, wbif.w_rd_store_o}, 32'h0);
        @(posedge clk);
        #1;
      end
    end
    check({tag, "_stall_now"}, {31'h0, wbif.w_stall_o}, 32'h0);
    check({tag, "_stall_cycles"}, stalls, v.e_stall);
    check({tag, "_store"}, {31'h0, wbif.w_rd_store_o}, {31'h0, v.e_store});
    check({tag, "_byp_wr"}, {31'h0, wbif.w_bypass_rd_write_o}, {31'h0, v.e_store});
    check({tag, "_mis"}, {31'h0, wbif.w_misaligned_o}, {31'h0, v.e_mis});
    check({tag, "_rd"}, {27'h0, wbif.w_rd_o}, {27'h0, v.rd});
    if (v.e_store) begin
      check({tag, "_value"}, wbif.w_rd_value_o, v.e_val);
      check({tag, "_byp_value"}, wbif.w_bypass_rd_value_o, v.e_val);
    end
    @(posedge clk);
    #1;
    wbif.dm_load_done_i  = 1'b0;
    wbif.dm_store_done_i = 1'b0;
  endtask

  initial begin
    //          rd     val           wr    ld    st    fun     addr  data          dly st    exp_val       mis   stalls
    vecs[0]  = '{5'd5,  32'h12345678, 1'b1, 1'b0, 1'b0, 3'b000, 2'd0, 32'h0,        0, 1'b1, 32'h12345678, 1'b0, 0};
    vecs[1]  = '{5'd0,  32'h11111111, 1'b1, 1'b0, 1'b0, 3'b000, 2'd0, 32'h0,        0, 1'b0, 32'h0,        1'b0, 0};
    vecs[2]  = '{5'd7,  32'h22222222, 1'b0, 1'b0, 1'b0, 3'b000, 2'd0, 32'h0,        0, 1'b0, 32'h0,        1'b0, 0};
    vecs[3]  = '{5'd9,  32'h0,        1'b1, 1'b1, 1'b0, 3'b000, 2'd3, 32'h80FFFFFF, 3, 1'b1, 32'hFFFFFF80, 1'b0, 3};
    vecs[4]  = '{5'd10, 32'h0,        1'b1, 1'b1, 1'b0, 3'b101, 2'd2, 32'h80FFFFFF, 1, 1'b1, 32'h000080FF, 1'b0, 1};
    vecs[5]  = '{5'd11, 32'h0,        1'b1, 1'b1, 1'b0, 3'b100, 2'd1, 32'h1234C578, 0, 1'b1, 32'h000000C5, 1'b0, 0};
    vecs[6]  = '{5'd12, 32'h0,        1'b1, 1'b1, 1'b0, 3'b000, 2'd1, 32'h1234C578, 2, 1'b1, 32'hFFFFFFC5, 1'b0, 2};
    vecs[7]  = '{5'd13, 32'h0,        1'b1, 1'b1, 1'b0, 3'b001, 2'd0, 32'h1234C578, 0, 1'b1, 32'hFFFFC578, 1'b0, 0};
    vecs[8]  = '{5'd14, 32'h0,        1'b1, 1'b1, 1'b0, 3'b010, 2'd0, 32'hDEADBEEF, 1, 1'b1, 32'hDEADBEEF, 1'b0, 1};
    vecs[9]  = '{5'd15, 32'h0,        1'b1, 1'b1, 1'b0, 3'b010, 2'd2, 32'hDEADBEEF, 0, 1'b0, 32'h0,        1'b1, 0};
    vecs[10] = '{5'd16, 32'h0,        1'b1, 1'b1, 1'b0, 3'b001, 2'd1, 32'hDEADBEEF, 0, 1'b0, 32'h0,        1'b1, 0};
    vecs[11] = '{5'd17, 32'h0,        1'b0, 1'b0, 1'b1, 3'b010, 2'd0, 32'h0,        2, 1'b0, 32'h0,        1'b0, 2};
    vecs[12] = '{5'd18, 32'h0,        1'b1, 1'b1, 1'b0, 3'b011, 2'd0, 32'hCAFEF00D, 0, 1'b1, 32'hCAFEF00D, 1'b0, 0};
    vecs[13] = '{5'd19, 32'h0,        1'b1, 1'b1, 1'b0, 3'b001, 2'd2, 32'h80017FFF, 1, 1'b1, 32'hFFFF8001, 1'b0, 1};

    set_x(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0);
    wbif.dm_data_l_i     = 32'h0;
    wbif.dm_load_done_i  = 1'b0;
    wbif.dm_store_done_i = 1'b0;

    // Reset state
    #12;
    check("rst_stall", {31'h0, wbif.w_stall_o}, 32'h0);
    check("rst_store", {31'h0, wbif.w_rd_store_o}, 32'h0);
    check("rst_rd", {27'h0, wbif.w_rd_o}, 32'h0);
    check("rst_mis", {31'h0, wbif.w_misaligned_o}, 32'h0);
    check("rst_buserr", {31'h0, wbif.w_bus_error_o}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

    // Store followed back-to-back by an ALU op
    @(negedge clk);
    set_x(1'b1, 5'd20, 32'h0, 1'b0, 1'b0, 1'b1, 3'b010, 2'd0);
    @(posedge clk);
    #1;
    set_x(1'b1, 5'd3, 32'h0000A5A5, 1'b1, 1'b0, 1'b0, 3'd0, 2'd0);
    check("st_alu_stall1", {31'h0, wbif.w_stall_o}, 32'h1);
    @(posedge clk);
    #1;
    check("st_alu_stall2", {31'h0, wbif.w_stall_o}, 32'h1);
    wbif.dm_store_done_i = 1'b1;
    #1;
    check("st_alu_done_stall", {31'h0, wbif.w_stall_o}, 32'h0);
    check("st_alu_done_store", {31'h0, wbif.w_rd_store_o}, 32'h0);
    @(posedge clk);
    #1;
    wbif.dm_store_done_i = 1'b0;
    wbif.x_valid_i = 1'b0;
    check("st_alu_wr", {31'h0, wbif.w_rd_store_o}, 32'h1);
    check("st_alu_rd", {27'h0, wbif.w_rd_o}, 32'd3);
    check("st_alu_val", wbif.w_rd_value_o, 32'h0000A5A5);
    @(posedge clk);
    #1;

    // Reset while waiting on a load
    @(negedge clk);
    set_x(1'b1, 5'd4, 32'h0, 1'b1, 1'b1, 1'b0, 3'b010, 2'd0);
    wbif.dm_data_l_i = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    wbif.x_valid_i = 1'b0;
    check("rstw_stall_before", {31'h0, wbif.w_stall_o}, 32'h1);
    #1;
    rst_n = 1'b0;
    wbif.dm_load_done_i = 1'b1;
    #1;
    check("rstw_stall", {31'h0, wbif.w_stall_o}, 32'h0);
    check("rstw_store", {31'h0, wbif.w_rd_store_o}, 32'h0);
    check("rstw_rd", {27'h0, wbif.w_rd_o}, 32'h0);
    check("rstw_value", wbif.w_rd_value_o, 32'h0);
    check("rstw_byp", {31'h0, wbif.w_bypass_rd_write_o}, 32'h0);
    check("rstw_mis", {31'h0, wbif.w_misaligned_o}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rstw_after_store", {31'h0, wbif.w_rd_store_o}, 32'h0);
    check("rstw_after_stall", {31'h0, wbif.w_stall_o}, 32'h0);
    wbif.dm_load_done_i = 1'b0;

    // Load with no completion for a long time
    @(negedge clk);
    set_x(1'b1, 5'd6, 32'h0, 1'b1, 1'b1, 1'b0, 3'b010, 2'd0);
    wbif.dm_data_l_i = 32'h600DF00D;
    @(posedge clk);
    #1;
    wbif.x_valid_i = 1'b0;
`ifdef KMKZ_WB_LOAD_TIMEOUT_EN
    for (int c = 0; c < 4; c++) begin
      check($sformatf("to_stall%0d", c), {31'h0, wbif.w_stall_o}, 32'h1);
      check($sformatf("to_err%0d", c), {31'h0, wbif.w_bus_error_o}, 32'h0);
      @(posedge clk);
      #1;
    end
    check("to_err_pulse", {31'h0, wbif.w_bus_error_o}, 32'h1);
    check("to_stall_drop", {31'h0, wbif.w_stall_o}, 32'h0);
    check("to_no_write", {31'h0, wbif.w_rd_store_o}, 32'h0);
    @(posedge clk);
    #1;
    check("to_err_clear", {31'h0, wbif.w_bus_error_o}, 32'h0);
`else
    for (int c = 0; c < 8; c++) begin
      check($sformatf("long_stall%0d", c), {31'h0, wbif.w_stall_o}, 32'h1);
      check($sformatf("long_err%0d", c), {31'h0, wbif.w_bus_error_o}, 32'h0);
      @(posedge clk);
      #1;
    end
    wbif.dm_load_done_i = 1'b1;
    #1;
    check("long_store", {31'h0, wbif.w_rd_store_o}, 32'h1);
    check("long_value", wbif.w_rd_value_o, 32'h600DF00D);
    @(posedge clk);
    #1;
    wbif.dm_load_done_i = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
